// File: rtl/synth_pkg.sv
// Shared types and constants for the poly_synth tone generator:
// waveform encodings, envelope limits and the quarter-wave sine table.
package synth_pkg;

  typedef enum logic [1:0] {
    WAVE_SQUARE = 2'd0,
    WAVE_SAW    = 2'd1,
    WAVE_TRI    = 2'd2,
    WAVE_SINE   = 2'd3
  } wave_e;

  localparam int ENV_W = 8;
  localparam logic [ENV_W-1:0] ENV_MAX = 8'd255;

  localparam int ROM_AW = 6;

  // 128 + round(127*sin(2*pi*i/256)), first quadrant only
  localparam logic [7:0] SINE_Q [64] = '{
    8'd128, 8'd131, 8'd134, 8'd137, 8'd140, 8'd144, 8'd147, 8'd150,
    8'd153, 8'd156, 8'd159, 8'd162, 8'd165, 8'd168, 8'd171, 8'd174,
    8'd177, 8'd179, 8'd182, 8'd185, 8'd188, 8'd191, 8'd193, 8'd196,
    8'd199, 8'd201, 8'd204, 8'd206, 8'd209, 8'd211, 8'd213, 8'd216,
    8'd218, 8'd220, 8'd222, 8'd224, 8'd226, 8'd228, 8'd230, 8'd232,
    8'd234, 8'd235, 8'd237, 8'd239, 8'd240, 8'd241, 8'd243, 8'd244,
    8'd245, 8'd246, 8'd248, 8'd249, 8'd250, 8'd250, 8'd251, 8'd252,
    8'd253, 8'd253, 8'd254, 8'd254, 8'd254, 8'd255, 8'd255, 8'd255
  };

endpackage

// File: rtl/synth_voice.sv
// One DDS voice: phase accumulator and envelope on tick, waveform
// shaping, then envelope multiply; sample valid three cycles after tick.
module synth_voice
  import synth_pkg::*;
#(
  parameter int PHASE_W      = 24,
  parameter int SAMPLE_W     = 8,
  parameter int ATTACK_STEP  = 4,
  parameter int RELEASE_STEP = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick,
  input  logic                gate,
  input  logic [PHASE_W-1:0]  fcw,
  input  wave_e               wave_sel,
  output logic                active,
  output logic [SAMPLE_W-1:0] sample
);

  logic [PHASE_W-1:0]  phase;
  logic [ENV_W-1:0]    env;
  logic [ENV_W-1:0]    env_nx;
  logic [ENV_W:0]      env_up;
  logic                gate_q;
  wave_e               ws;

  assign env_up = {1'b0, env} + (ENV_W+1)'(ATTACK_STEP);

  always_comb begin
    env_nx = '0;
    if (gate)
      env_nx = (env_up > {1'b0, ENV_MAX}) ? ENV_MAX
                                          : env_up[ENV_W-1:0];
    else if (env > ENV_W'(RELEASE_STEP))
      env_nx = env - ENV_W'(RELEASE_STEP);
  end

  // a finished release parks phase at 0 so the next note starts clean
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase  <= '0;
      env    <= '0;
      gate_q <= 1'b0;
      ws     <= WAVE_SQUARE;
    end else if (tick) begin
      env    <= env_nx;
      gate_q <= gate;
      ws     <= wave_sel;
      if (!gate && env_nx == '0)
        phase <= '0;
      else
        phase <= phase + fcw;
    end
  end

  assign active = gate_q | (env != '0);

  logic [SAMPLE_W-1:0] p;
  logic [1:0]          quad;
  logic [ROM_AW-1:0]   ridx;
  logic [SAMPLE_W-1:0] rom_v;
  logic [SAMPLE_W-1:0] sin_v;
  logic [SAMPLE_W-1:0] tri_v;
  logic [SAMPLE_W-1:0] wave;
  logic [SAMPLE_W-1:0] wave_q;

  assign p     = phase[PHASE_W-1 -: SAMPLE_W];
  assign quad  = p[SAMPLE_W-1 -: 2];
  assign ridx  = quad[0] ? ~p[SAMPLE_W-3 -: ROM_AW]
                         :  p[SAMPLE_W-3 -: ROM_AW];
  assign rom_v = SAMPLE_W'(SINE_Q[ridx]) << (SAMPLE_W-8);
  assign sin_v = quad[1] ? ~rom_v : rom_v;
  assign tri_v = p[SAMPLE_W-1] ? ~{p[SAMPLE_W-2:0], 1'b0}
                               :  {p[SAMPLE_W-2:0], 1'b0};

  always_comb begin
    wave = p;
    unique case (1'b1)
      (ws == WAVE_SQUARE): wave = {SAMPLE_W{p[SAMPLE_W-1]}};
      (ws == WAVE_SAW):    wave = p;
      (ws == WAVE_TRI):    wave = tri_v;
      (ws == WAVE_SINE):   wave = sin_v;
    endcase
  end

  logic [SAMPLE_W+ENV_W-1:0] prod;

  assign prod = {{ENV_W{1'b0}}, wave_q} * {{SAMPLE_W{1'b0}}, env};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wave_q <= '0;
      sample <= '0;
    end else begin
      wave_q <= wave;
      sample <= SAMPLE_W'(prod >> ENV_W);
    end
  end

endmodule

// File: rtl/poly_synth.sv
// Polyphonic DDS tone generator for the speaker Pmod: sample divider,
// voices, mixer with master volume, PWM output and amp enable.
module poly_synth
  import synth_pkg::*;
#(
  parameter int NUM_VOICES   = 4,
  parameter int PHASE_W      = 24,
  parameter int SAMPLE_W     = 8,
  parameter int PWM_W        = 8,
  parameter int SAMPLE_DIV   = 2048,
  parameter int ATTACK_STEP  = 4,
  parameter int RELEASE_STEP = 1
) (
  input  logic                          CLK100MHZ,
  input  logic                          ck_rst,
  input  logic [NUM_VOICES-1:0]         gate,
  input  logic [NUM_VOICES*PHASE_W-1:0] fcw,
  input  logic [1:0]                    wave_sel,
  input  logic [3:0]                    volume,
  output logic                          pwm_out,
  output logic                          amp_en,
  output logic                          sample_tick
);

  localparam int VW    = $clog2(NUM_VOICES);
  localparam int MIX_W = SAMPLE_W + VW;
  localparam int DIV_W = $clog2(SAMPLE_DIV);

  // assert immediately, release two clocks later
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge CLK100MHZ or negedge ck_rst) begin
    if (!ck_rst) rst_sync <= '0;
    else         rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  logic [DIV_W-1:0] div_cnt;

  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt     <= '0;
      sample_tick <= 1'b0;
    end else begin
      sample_tick <= (div_cnt == '0);
      div_cnt     <= (div_cnt == '0) ? DIV_W'(SAMPLE_DIV-1)
                                     : div_cnt - DIV_W'(1);
    end
  end

  logic [SAMPLE_W-1:0]   vsamp [NUM_VOICES];
  logic [NUM_VOICES-1:0] vact;

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
    synth_voice #(
      .PHASE_W      (PHASE_W),
      .SAMPLE_W     (SAMPLE_W),
      .ATTACK_STEP  (ATTACK_STEP),
      .RELEASE_STEP (RELEASE_STEP)
    ) u_voice (
      .clk      (CLK100MHZ),
      .rst_n    (rst_n),
      .tick     (sample_tick),
      .gate     (gate[v]),
      .fcw      (fcw[v*PHASE_W +: PHASE_W]),
      .wave_sel (wave_e'(wave_sel)),
      .active   (vact[v]),
      .sample   (vsamp[v])
    );
  end

  logic [MIX_W-1:0]    mix_sum;
  logic [SAMPLE_W-1:0] mix;

  always_comb begin
    mix_sum = '0;
    for (int i = 0; i < NUM_VOICES; i++)
      mix_sum = mix_sum + MIX_W'(vsamp[i]);
  end

  assign mix = SAMPLE_W'(mix_sum >> VW);

  logic [2:0]          tick_sr;
  logic [3:0]          vol_q;
  logic [4:0]          vol_p1;
  logic [SAMPLE_W+4:0] lvl_prod;
  logic [SAMPLE_W-1:0] level;

  assign vol_p1   = {1'b0, vol_q} + 5'd1;
  assign lvl_prod = {5'b0, mix} * (SAMPLE_W+5)'(vol_p1);

  // level only moves once the tick has crossed the voice pipeline
  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      tick_sr <= '0;
      vol_q   <= '0;
      level   <= '0;
    end else begin
      tick_sr <= {tick_sr[1:0], sample_tick};
      if (sample_tick) vol_q <= volume;
      if (tick_sr[2])  level <= SAMPLE_W'(lvl_prod >> 4);
    end
  end

  logic [PWM_W-1:0] pwm_cnt;

  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
      pwm_out <= 1'b0;
      amp_en  <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_W'(1);
      pwm_out <= (level[SAMPLE_W-1 -: PWM_W] > pwm_cnt);
      amp_en  <= |vact;
    end
  end

endmodule
